// File: rtl/seq_mul16_pkg.sv
// Shared types and constants for the sequential 16x16 multiplier built on alu16bit.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'b00,
    BOOTH_ADD = 2'b01,
    BOOTH_SUB = 2'b10
  } booth_e;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [1:0] ALU_SLT = 2'b11;

  localparam int ITER = 16;

  // Radix-2 Booth recoding of the current multiplier bit and the bit shifted out last step.
  function automatic booth_e booth_dec(input logic q0, input logic qm1);
    booth_e op;
    case ({q0, qm1})
      2'b01:   op = BOOTH_ADD;
      2'b10:   op = BOOTH_SUB;
      default: op = BOOTH_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/seq_mul16.sv
// Sequential 16x16 multiplier: one add/subtract-and-shift step per clock through an
// external combinational alu16bit, unsigned shift-add or signed radix-2 Booth.
module seq_mul16
  import seq_mul_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        signed_mode,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output logic [15:0] alu_src1,
  output logic [15:0] alu_src2,
  output logic        alu_A_invert,
  output logic        alu_B_invert,
  output logic        alu_cin,
  output logic [1:0]  alu_operation,
  output logic        alu_less,
  input  logic [15:0] alu_result,
  input  logic        alu_msbcin,
  input  logic        alu_g,
  input  logic        alu_p
);

  localparam logic [4:0] LAST_CNT = 5'(ITER - 1);

  state_e      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] q_q, q_d;
  logic        qm1_q, qm1_d;
  logic [15:0] m_q, m_d;
  logic        mode_q, mode_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] product_q, product_d;

  booth_e      booth_op_s;
  logic        sub_s, last_s, cout_s, ovf_s, ext_s;
  logic [15:0] sum_s, step_acc_s, step_q_s;

  assign booth_op_s = booth_dec(q_q[0], qm1_q);
  assign sub_s      = (state_q == RUN) && mode_q && (booth_op_s == BOOTH_SUB);
  assign last_s     = (cnt_q == LAST_CNT);
  assign cout_s     = alu_g | (alu_p & sub_s);
  assign ovf_s      = alu_msbcin ^ cout_s;

  // Shift-in bit: carry-out for unsigned, true sign of the 17-bit sum for Booth.
  always_comb begin
    sum_s = acc_q;
    ext_s = 1'b0;
    if (mode_q) begin
      if (booth_op_s == BOOTH_NOP) begin
        sum_s = acc_q;
        ext_s = acc_q[15];
      end else begin
        sum_s = alu_result;
        ext_s = alu_result[15] ^ ovf_s;
      end
    end else begin
      if (q_q[0]) begin
        sum_s = alu_result;
        ext_s = cout_s;
      end else begin
        sum_s = acc_q;
        ext_s = 1'b0;
      end
    end
  end

  assign step_acc_s = {ext_s, sum_s[15:1]};
  assign step_q_s   = {sum_s[0], q_q[15:1]};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
        else       state_d = IDLE;
      end
      RUN: begin
        if (last_s) state_d = DONE;
        else        state_d = RUN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from registered state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath next-state: load on accept, one step per RUN cycle, capture product on the last step.
  always_comb begin
    acc_d     = acc_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    m_d       = m_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d    = a;
          q_d    = b;
          acc_d  = 16'h0000;
          qm1_d  = 1'b0;
          mode_d = signed_mode;
          cnt_d  = 5'd0;
        end else begin
          cnt_d = cnt_q;
        end
      end
      RUN: begin
        acc_d = step_acc_s;
        q_d   = step_q_s;
        qm1_d = q_q[0];
        cnt_d = cnt_q + 5'd1;
        if (last_s) product_d = {step_acc_s, step_q_s};
        else        product_d = product_q;
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= 16'h0000;
      q_q       <= 16'h0000;
      qm1_q     <= 1'b0;
      m_q       <= 16'h0000;
      mode_q    <= 1'b0;
      cnt_q     <= 5'd0;
      product_q <= 32'h0000_0000;
    end else begin
      acc_q     <= acc_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      m_q       <= m_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign product       = product_q;
  assign alu_src1      = acc_q;
  assign alu_src2      = m_q;
  assign alu_A_invert  = 1'b0;
  assign alu_B_invert  = sub_s;
  assign alu_cin       = sub_s;
  assign alu_operation = ALU_ADD;
  assign alu_less      = 1'b0;

endmodule
